// File: rtl/klingon_scan_display.sv
// Time-multiplexed multi-digit 7-segment driver with decimal/Klingon glyphs, leading-zero blanking
// and a shadow load that reaches the display only at frame boundaries; seg/dig_en lag idx by one cycle.
module klingon_scan_display #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] value,
  input  logic                load,
  input  logic                mode,
  input  logic                lz_blank,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   dig_en,
  output logic                frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]       pre;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] disp;
  logic [4*DIGITS-1:0] shadow;
  logic                pending;

  logic                pre_wrap;
  logic                last_dig;
  logic                boundary;
  logic [3:0]          cur_nib;
  logic                cur_zero;
  logic                run_zero;
  logic [DIGITS-1:0]   zero_above;
  logic [DIGITS-1:0]   onehot_nxt;
  logic                blank;

  function automatic logic [6:0] glyph(input logic [3:0] n, input logic klingon);
    logic [6:0] g;
    g = 7'b0000000;
    if (!klingon) begin
      case (n)
        4'd0: g = 7'b1111110;
        4'd1: g = 7'b0110000;
        4'd2: g = 7'b1101101;
        4'd3: g = 7'b1111001;
        4'd4: g = 7'b0110011;
        4'd5: g = 7'b1011011;
        4'd6: g = 7'b1011111;
        4'd7: g = 7'b1110000;
        4'd8: g = 7'b1111111;
        4'd9: g = 7'b1111011;
        default: g = 7'b0000000;
      endcase
    end else begin
      case (n)
        4'd0: g = 7'b1111110;
        4'd1: g = 7'b1000000;
        4'd2: g = 7'b1000001;
        4'd3: g = 7'b1001001;
        4'd4: g = 7'b0100011;
        4'd5: g = 7'b0011101;
        4'd6: g = 7'b0100101;
        4'd7: g = 7'b0010011;
        4'd8: g = 7'b0110110;
        4'd9: g = 7'b0110111;
        default: g = 7'b0000000;
      endcase
    end
    return g;
  endfunction

  assign pre_wrap = (pre == PW'(PRESCALE - 1));
  assign last_dig = (idx == IW'(DIGITS - 1));
  assign boundary = pre_wrap && last_dig;

  // zero_above[i]: nibbles i..DIGITS-1 of disp are all zero
  always_comb begin
    run_zero   = 1'b1;
    zero_above = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run_zero      = run_zero && (disp[4*i +: 4] == 4'd0);
      zero_above[i] = run_zero;
    end
  end

  always_comb begin
    cur_nib    = 4'd0;
    cur_zero   = 1'b0;
    onehot_nxt = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib       = disp[4*i +: 4];
        cur_zero      = zero_above[i];
        onehot_nxt[i] = 1'b1;
      end
    end
    blank = lz_blank && (idx != '0) && cur_zero;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre        <= '0;
      idx        <= '0;
      disp       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      seg        <= 7'b0000000;
      dig_en     <= '0;
      frame_done <= 1'b0;
    end else begin
      pre <= pre_wrap ? '0 : pre + PW'(1);
      if (pre_wrap) begin
        idx <= last_dig ? '0 : idx + IW'(1);
      end
      frame_done <= boundary;

      // A load landing on the boundary goes straight to the display
      if (load && boundary) begin
        disp    <= value;
        shadow  <= value;
        pending <= 1'b0;
      end else if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end else if (boundary && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
      end

      dig_en <= onehot_nxt;
      seg    <= blank ? 7'b0000000 : glyph(cur_nib, mode);
    end
  end

endmodule
